reg_dump_reader: RTL and testbench

Debug reader for the 32×32 register file. On a start pulse it walks a programmable, wrapping address range through a register-file read port. It captures each word and streams it out as (address, data) beats on a valid/ready handshake toward the debug/UART path. It sits beside the datapath and shares one combinational read port with it while busy.

---
 rtl/reg_dump_reader_pkg.sv | 15 +
 rtl/reg_dump_reader.sv | 106 ++++++++++
 tb/tb_reg_dump_reader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared widths and dump-FSM encodings for the register-file debug reader.
// The state values stay fixed so the debug path can decode them.
package reg_dump_reader_pkg;

  localparam int DATA_LEN     = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int REG_NUM      = 1 << REG_ADDR_LEN;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_FETCH = 2'd1,
    DUMP_SEND  = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a wrapping register range through the shared read port and streams
// each word out as an (address, data) beat on a valid/ready handshake.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int DATA_W = DATA_LEN,
  parameter int ADDR_W = REG_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, end_q;
  logic              load, capture, advance, finish, handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DUMP_IDLE;
    else     state_q <= state_d;
  end

  assign handshake = (state_q == DUMP_SEND) && out_valid && out_ready;

  // abort overrides everything, including a final handshake in the same cycle
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    if (abort) begin
      state_d = DUMP_IDLE;
    end else begin
      case (state_q)
        DUMP_IDLE: begin
          if (start) begin
            load    = 1'b1;
            state_d = DUMP_FETCH;
          end
        end
        DUMP_FETCH: begin
          capture = 1'b1;
          state_d = DUMP_SEND;
        end
        DUMP_SEND: begin
          if (handshake) begin
            if (out_last) begin
              finish  = 1'b1;
              state_d = DUMP_IDLE;
            end else begin
              advance = 1'b1;
              state_d = DUMP_FETCH;
            end
          end
        end
        default: state_d = DUMP_IDLE;
      endcase
    end
  end

  // Range registers and the registered output beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q     <= '0;
      end_q     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        cur_q <= first_addr;
        end_q <= last_addr;
      end else if (advance) begin
        cur_q <= cur_q + ADDR_W'(1);
      end
      if (capture) begin
        out_addr <= cur_q;
        out_data <= rf_data;
        out_last <= (cur_q == end_q);
      end
      if (abort)          out_valid <= 1'b0;
      else if (capture)   out_valid <= 1'b1;
      else if (handshake) out_valid <= 1'b0;
    end
  end

  assign rf_addr = cur_q;
  assign busy    = (state_q != DUMP_IDLE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized self-checking bench for reg_dump_reader against a range/beat-list model.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr, last_addr;
  logic        abort;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last, busy, done;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rf_data = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];

  reg_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr),
    .last_addr(last_addr), .abort(abort), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  // Runs one dump; mode 0 ready always high, 1 toggling, 2 random.
  task automatic do_dump(input int first, input int last, input int mode, input bit inject);
    int          ea[$];
    logic [31:0] ed[$];
    bit          el[$];
    int          n, idx;
    bit          got_done, expect_done, held, r;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic        h_last;
    n = ((last - first + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      int a;
      a = (first + k) % 32;
      ea.push_back(a);
      ed.push_back(a == 0 ? 32'd0 : regs[a]);
      el.push_back(k == n - 1);
    end
    @(negedge clk);
    start = 1'b1; first_addr = 5'(first); last_addr = 5'(last);
    @(negedge clk);
    start = 1'b0;
    idx = 1; got_done = 0; expect_done = 0; held = 0;
    h_addr = '0; h_data = '0; h_last = 1'b0;
    while (!got_done && idx < 400) begin
      total++;
      if (expect_done) begin
        if (done !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL done_pulse range %0d..%0d: done=%b busy=%b, required done=1 busy=0", first, last, done, busy);
        end
        got_done = 1;
        if (mode == 0) begin
          total++;
          if (idx != 2 * n + 1) begin
            bad++;
            $display("FAIL done_latency range %0d..%0d: %0d cycles, required %0d", first, last, idx, 2 * n + 1);
          end
        end
      end else if (done !== 1'b0) begin
        bad++;
        $display("FAIL early_done range %0d..%0d: done=%b at cycle %0d, required 0", first, last, done, idx);
      end
      if (!got_done) begin
        if (held) begin
          total++;
          if (out_valid !== 1'b1 || out_addr !== h_addr || out_data !== h_data || out_last !== h_last) begin
            bad++;
            $display("FAIL stall_stable: valid=%b addr=%0d data=%h last=%b, required 1 %0d %h %b",
                     out_valid, out_addr, out_data, out_last, h_addr, h_data, h_last);
          end
        end
        start = 1'b0;
        if (inject && idx == 3) begin
          start = 1'b1; first_addr = 5'd10; last_addr = 5'd12;
        end
        case (mode)
          0:       r = 1'b1;
          1:       r = idx[0];
          default: r = 1'($urandom_range(1, 0));
        endcase
        out_ready = r;
        held = 0;
        if (out_valid === 1'b1) begin
          if (r) begin
            total++;
            if (ea.size() == 0) begin
              bad++;
              $display("FAIL extra_beat: addr=%0d data=%h, required no beat", out_addr, out_data);
            end else begin
              if (out_addr !== 5'(ea[0]) || out_data !== ed[0] || out_last !== el[0]) begin
                bad++;
                $display("FAIL beat: addr=%0d data=%h last=%b, required %0d %h %b",
                         out_addr, out_data, out_last, ea[0], ed[0], el[0]);
              end
              if (el[0]) expect_done = 1;
              void'(ea.pop_front()); void'(ed.pop_front()); void'(el.pop_front());
            end
          end else begin
            held = 1; h_addr = out_addr; h_data = out_data; h_last = out_last;
          end
        end
        @(negedge clk);
        idx++;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    total++;
    if (!got_done || ea.size() != 0) begin
      bad++;
      $display("FAIL dump_complete range %0d..%0d: done_seen=%0d beats_left=%0d, required 1 and 0", first, last, got_done, ea.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    repeat (2) @(negedge clk);
    total++;
    if (rf_addr !== 0 || out_valid !== 0 || out_addr !== 0 || out_data !== 0 ||
        out_last !== 0 || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_values: rf_addr=%0d valid=%b addr=%0d data=%h last=%b busy=%b done=%b, required all 0",
               rf_addr, out_valid, out_addr, out_data, out_last, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_beat;
    regs[5] = 32'hDEADBEEF;
    do_dump(5, 5, 0, 0);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_after: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_full_backpressure;
    for (int i = 0; i < 32; i++) regs[i] = i * 32'h11111111;
    do_dump(0, 31, 1, 0);
    do_dump(0, 31, 0, 0);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_dump(30, 1, 2, 0);
    do_dump(9, 8, 0, 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      do_dump(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), t % 3, 0);
    end
  endtask

  task automatic test_abort;
    int beats;
    bit hit;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
    @(negedge clk);
    start = 1'b0;
    beats = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      if (out_valid === 1'b1) begin
        if (beats < 2) begin
          out_ready = 1'b1; beats++;
        end else begin
          total++;
          if (out_addr !== 5'd2) begin
            bad++;
            $display("FAIL abort_third_beat: addr=%0d, required 2", out_addr);
          end
          out_ready = 1'b0; abort = 1'b1; hit = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    total++;
    if (!hit || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_effect: reached=%0d valid=%b busy=%b done=%b, required 1 0 0 0", hit, out_valid, busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
    end
    do_dump(7, 9, 2, 0);
  endtask

  task automatic test_start_while_busy;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_dump(0, 3, 1, 1);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; first_addr = 5'd4; last_addr = 5'd6;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL start_abort_idle: busy=%b valid=%b done=%b, required 0 0 0", busy, out_valid, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    for (int i = 0; i < 32; i++) regs[i] = $urandom | 32'h1;
    @(negedge clk);
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd9; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (!seen || rf_addr !== 0 || out_valid !== 0 || out_addr !== 0 || out_data !== 0 ||
        out_last !== 0 || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL async_reset: reached=%0d rf_addr=%0d valid=%b addr=%0d data=%h last=%b busy=%b done=%b, required 1 and all 0",
               seen, rf_addr, out_valid, out_addr, out_data, out_last, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: done=%b busy=%b, required 0 0", done, busy);
    end
    do_dump(20, 22, 2, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    test_reset();
    test_single_beat();
    test_full_backpressure();
    test_wrap();
    test_random();
    test_abort();
    test_start_while_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
